// File: rtl/lcd_digit_renderer_pkg.sv
// rtl/lcd_digit_renderer_pkg.sv - glyph ROM geometry and renderer FSM encoding
package lcd_digit_renderer_pkg;

    localparam int LCD_GLYPH_ROWS  = 16;
    localparam int LCD_ROM_DEPTH   = 160;
    localparam int LCD_GLYPH_COUNT = LCD_ROM_DEPTH / LCD_GLYPH_ROWS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/lcd_digit_renderer.sv
// rtl/lcd_digit_renderer.sv - walks the digit glyph ROM row-major and streams pixel bytes
module lcd_digit_renderer
    import lcd_digit_renderer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  blank_lz,
    output logic [7:0]            rom_addr,
    input  logic [7:0]            rom_data,
    output logic [7:0]            pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [3:0]            pix_row,
    output logic [2:0]            pix_col,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  done
);

    state_e              state_q;
    logic [3:0]          row_q;
    logic [2:0]          col_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic                blank_q;
    logic [7:0]          pix_data_q;
    logic                pix_valid_q;
    logic                pix_last_q;
    logic                busy_q;
    logic                done_q;

    logic [3:0]          digit;
    logic                digit_blank;
    logic                digit_bad;
    logic                last_pos;
    logic [DIGITS-1:0]   blank_mask;

    // A column is blank while every digit from the left edge up to it is zero;
    // the rightmost column always shows, so a zero value still renders "0".
    function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v, input logic en);
        logic [DIGITS-1:0] m;
        logic              zero_run;
        m        = '0;
        zero_run = en;
        for (int c = 0; c < DIGITS; c++) begin
            zero_run = zero_run && (v[4*(DIGITS-1-c) +: 4] == 4'd0);
            m[c]     = zero_run && (c != DIGITS-1);
        end
        return m;
    endfunction

    assign blank_mask = lz_mask(bcd_q, blank_q);

    always_comb begin
        digit       = 4'd0;
        digit_blank = 1'b0;
        for (int c = 0; c < DIGITS; c++) begin
            if (col_q == 3'(c)) begin
                digit       = bcd_q[4*(DIGITS-1-c) +: 4];
                digit_blank = blank_mask[c];
            end
        end
    end

    assign digit_bad = (digit >= 4'(LCD_GLYPH_COUNT));
    assign last_pos  = (row_q == 4'(LCD_GLYPH_ROWS-1)) && (col_q == 3'(DIGITS-1));

    // Invalid digits address glyph 0 so the ROM never sees an address past its depth.
    assign rom_addr = (state_q == ST_FETCH && !digit_bad) ? {digit, row_q} : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= 4'd0;
            col_q       <= 3'd0;
            bcd_q       <= '0;
            blank_q     <= 1'b0;
            pix_data_q  <= 8'd0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bcd_q   <= bcd_in;
                        blank_q <= blank_lz;
                        row_q   <= 4'd0;
                        col_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    pix_data_q  <= (digit_bad || digit_blank) ? 8'd0 : rom_data;
                    pix_last_q  <= last_pos;
                    pix_valid_q <= 1'b1;
                    state_q     <= ST_SEND;
                end
                ST_SEND: begin
                    if (pix_ready) begin
                        pix_valid_q <= 1'b0;
                        if (pix_last_q) begin
                            pix_last_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            if (col_q == 3'(DIGITS-1)) begin
                                col_q <= 3'd0;
                                row_q <= row_q + 4'd1;
                            end else begin
                                col_q <= col_q + 3'd1;
                            end
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign pix_row   = row_q;
    assign pix_col   = col_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/lcd_digit_renderer.md
# lcd_digit_renderer

Sequencer for the 16×8 digit glyph ROM (`LCD_NUMBER_ROM`, 160 bytes, address = digit×16 + row). On a start request it latches a packed BCD value and walks the ROM row-major: all digits of glyph row 0, then row 1, and so on through row 15. It streams one 8-pixel byte per beat to the LCD write path over a valid/ready handshake. It sits between the display-update logic and the LCD pixel writer on the Arty S7 design. The ROM is instantiated at top level and driven only by this block.

## Interface
Parameters:
- `DIGITS`, default 4: number of glyphs rendered side by side. Legal range is 1..8.

Ports:
- `clk`: in, 1. System clock.
- `rst_n`: in, 1. Asynchronous, active-low reset.
- `start`: in, 1. Render request. Sampled only in IDLE.
- `bcd_in`: in, 4×DIGITS. Packed BCD. The top nibble is the leftmost digit.
- `blank_lz`: in, 1. Suppress leading zeros. Latched together with `bcd_in`.
- `rom_addr`: out, 8. Address to the ROM `addr_r`.
- `rom_data`: in, 8. ROM `data_r`, combinational read.
- `pix_data`: out, 8. Pixel byte. Bit 7 is the leftmost pixel.
- `pix_valid`: out, 1. `pix_data` is valid.
- `pix_ready`: in, 1. Downstream accepts the current beat.
- `pix_row`: out, 4. Glyph row of the current beat.
- `pix_col`: out, 3. Digit column of the current beat. Column 0 is leftmost.
- `pix_last`: out, 1. Final beat, i.e. row 15 and column DIGITS-1.
- `busy`: out, 1. High in every state except IDLE.
- `done`: out, 1. One-cycle pulse after the last beat is accepted.

## Operation
- FSM states are IDLE, FETCH, SEND and DONE.
- IDLE:
  - On `start`=1, latch `bcd_in` and `blank_lz`, clear row and column, and go to FETCH.
- FETCH (one cycle):
  - Drive `rom_addr = {digit, 4'b0} | row`.
  - At the clock edge, register `pix_data` and go to SEND.
- Value registered into `pix_data` in FETCH:
  - Normally `pix_data <= rom_data`.
  - It is 8'h00 if the digit is >9 (invalid BCD).
  - It is 8'h00 if the digit is blanked.
- Leading-zero blanking:
  - With `blank_lz`=1, a column is blanked if it and every column to its left hold 0.
  - Column DIGITS-1 is never blanked, so value 0 renders a single "0".
- Invalid BCD digit (>9):
  - `rom_addr` is forced to 0, so no address above 159 is ever issued.
  - The digit is still rendered as blank.
- SEND:
  - `pix_valid`=1. `pix_data`, `pix_row`, `pix_col` and `pix_last` are held stable until `pix_ready`=1.
  - On a handshake with `pix_last`=0, advance the column. When the column wraps from DIGITS-1 to 0, increment the row. Then go to FETCH.
  - On a handshake with `pix_last`=1, go to DONE.
- DONE:
  - Assert `done` for one cycle, then go to IDLE.
- `start` while busy is ignored. It is not queued.
- `bcd_in` changes after the latch have no effect until the next start.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - State = IDLE.
  - `rom_addr`=0 and `pix_data`=0.
  - `pix_valid`, `pix_last`, `busy` and `done` = 0.
  - `pix_row`=0 and `pix_col`=0.
  - Latched BCD = 0.
- Reset mid-frame aborts the frame:
  - No `done` is produced.
  - Rendering resumes only on a new `start` after reset is released.
- Start latency:
  - `start` is sampled at edge 0.
  - `busy`=1 and FETCH occupy cycle 1.
  - `pix_valid`=1 from cycle 2.
- Throughput: with `pix_ready` held at 1, there is one beat every 2 cycles.
- Frame length:
  - 16×DIGITS beats. `done` is asserted in the cycle after the final handshake.
  - With DIGITS=4 and no back-pressure, that is 64 beats, `done` at cycle 129, and IDLE at cycle 130.
- `pix_valid` never drops without a handshake. Data never changes while valid and not ready.
- The earliest next `start` is sampled the cycle after `done`.

## Structure
- Shared include `lcd_defs.vh` holds the following constants:
  - `LCD_GLYPH_ROWS`=16 and `LCD_GLYPH_COUNT`=10.
  - `LCD_ROM_DEPTH`=160.
  - The FSM state encodings (2 bits).
- There is no sub-module. The leading-zero mask is a small function or combinational always block inside the module.
- The ROM instance lives in the parent.

## Test plan
- **Single frame.** DIGITS=4, `bcd_in`=16'h1234, `blank_lz`=0, `pix_ready`=1.
  - Expect 64 beats.
  - The first four `rom_addr` values are 16, 32, 48, 64. The last is 79.
  - `pix_data` equals the ROM contents.
  - `pix_last` is asserted only on beat 64, with `done` one cycle later.
- **Leading zeros.** `bcd_in`=16'h0070, `blank_lz`=1.
  - Columns 0 and 1 output 8'h00 on every row.
  - Columns 2 and 3 output the glyphs "7" and "0".
  - With value 16'h0000, only column 3 is non-blank.
- **Back-pressure.** Hold `pix_ready`=0 for 5 cycles on beat 3, then toggle it randomly.
  - `pix_data`, `pix_row`, `pix_col` and `pix_valid` stay stable while stalled.
  - Beat order and count are unchanged.
- **Invalid BCD.** `bcd_in`=16'h9A0F.
  - Columns 1 and 3 render 8'h00 and drive `rom_addr`=0.
  - No address above 159 occurs.
- **Start while busy.** Pulse `start` again mid-frame with a different `bcd_in`.
  - The output frame still matches the first latched value.
  - Only one `done` is produced.
- **Async reset.** Assert `rst_n`=0 mid-beat with no clock edge.
  - All outputs go to their reset values immediately.
  - No `done` is produced.
  - A new `start` after release renders correctly from row 0.
